// File: rtl/psum_adder_pkg.sv
// rtl/psum_adder_pkg.sv - widths, kernel-size encodings and round helpers for the partial-sum adder
package psum_adder_pkg;

    localparam int PROD_W   = 16;
    localparam int NUM_LANE = 36;
    localparam int SEG_PROD = 128;
    localparam int TREE_IN  = 16;
    localparam int OUT_W    = 24;

    localparam int MUL_W    = NUM_LANE * SEG_PROD * PROD_W;
    localparam int PSUM_W   = NUM_LANE * OUT_W;
    localparam int SEG_W    = SEG_PROD * PROD_W;
    localparam int TREE_W   = TREE_IN * PROD_W;
    localparam int CNT_W    = 5;

    typedef enum logic [3:0] {
        WS_3X3 = 4'd0,
        WS_5X5 = 4'd1,
        WS_7X7 = 4'd2
    } wsize_e;

    // Number of taps (k*k) in a kernel; 0 for unsupported sizes.
    function automatic logic [6:0] kernel_taps(input logic [3:0] wsize);
        case (wsize)
            WS_3X3:  kernel_taps = 7'd9;
            WS_5X5:  kernel_taps = 7'd25;
            WS_7X7:  kernel_taps = 7'd49;
            default: kernel_taps = 7'd0;
        endcase
    endfunction

    function automatic logic [2:0] last_round(input logic [3:0] wsize);
        case (wsize)
            WS_3X3:  last_round = 3'd0;
            WS_5X5:  last_round = 3'd1;
            WS_7X7:  last_round = 3'd3;
            default: last_round = 3'd0;
        endcase
    endfunction

    // Products consumed in a given round: taps still outstanding, capped at the tree width.
    function automatic logic [CNT_W-1:0] round_count(input logic [3:0] wsize,
                                                     input logic [2:0] wround);
        logic [6:0] taps;
        logic [6:0] base;
        logic [6:0] rem;
        taps = kernel_taps(wsize);
        base = {wround, 4'b0000};
        rem  = taps - base;
        if (base >= taps) begin
            round_count = '0;
        end else if (rem > 7'(TREE_IN)) begin
            round_count = CNT_W'(TREE_IN);
        end else begin
            round_count = rem[CNT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/psum_adder_if.sv
// rtl/psum_adder_if.sv - product beat and Psum result bundle between multiplier array, adder and Psum buffer
interface psum_adder_if;
    import psum_adder_pkg::*;

    logic [3:0]        wsize;
    logic              stride;
    logic [2:0]        wround;
    logic [MUL_W-1:0]  MUL_results;
    logic              MUL_DATA_valid;
    logic              Psum_valid;
    logic [PSUM_W-1:0] Psum;

    modport master (
        output wsize, stride, wround, MUL_results, MUL_DATA_valid,
        input  Psum_valid, Psum
    );

    modport slave (
        input  wsize, stride, wround, MUL_results, MUL_DATA_valid,
        output Psum_valid, Psum
    );

endinterface

// File: rtl/psum_adder_adder_tree16.sv
// rtl/psum_adder_adder_tree16.sv - combinational 16-input signed adder tree with per-input enable
module adder_tree16
    import psum_adder_pkg::*;
(
    input  logic [TREE_W-1:0]       prod,
    input  logic [TREE_IN-1:0]      en,
    output logic signed [OUT_W-1:0] sum
);

    logic signed [OUT_W-1:0] lvl0 [16];
    logic signed [OUT_W-1:0] lvl1 [8];
    logic signed [OUT_W-1:0] lvl2 [4];
    logic signed [OUT_W-1:0] lvl3 [2];

    // Masked-off taps enter as zero so partial rounds reuse the full tree.
    for (genvar i = 0; i < 16; i++) begin : g_leaf
        assign lvl0[i] = en[i]
            ? {{(OUT_W-PROD_W){prod[i*PROD_W+PROD_W-1]}}, prod[i*PROD_W +: PROD_W]}
            : '0;
    end

    for (genvar i = 0; i < 8; i++) begin : g_l1
        assign lvl1[i] = lvl0[2*i] + lvl0[2*i+1];
    end

    for (genvar i = 0; i < 4; i++) begin : g_l2
        assign lvl2[i] = lvl1[2*i] + lvl1[2*i+1];
    end

    for (genvar i = 0; i < 2; i++) begin : g_l3
        assign lvl3[i] = lvl2[2*i] + lvl2[2*i+1];
    end

    assign sum = lvl3[0] + lvl3[1];

endmodule

// File: rtl/psum_adder.sv
// rtl/psum_adder.sv - per-lane round reduction and kernel accumulation (optional STRIDE_DECIM_EN)
module psum_adder
    import psum_adder_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    psum_adder_if.slave  bus
);

    logic [2:0]              lr;
    logic [CNT_W-1:0]        n_taps;
    logic [TREE_IN-1:0]      tap_en;
    logic                    accept;
    logic                    final_beat;
    logic                    first_round;
    logic [NUM_LANE-1:0]     lane_keep;
    logic [NUM_LANE-1:0]     unused_tail;

    logic signed [OUT_W-1:0] round_sum [NUM_LANE];
    logic signed [OUT_W-1:0] next_sum  [NUM_LANE];
    logic signed [OUT_W-1:0] acc       [NUM_LANE];
    logic [PSUM_W-1:0]       psum_q;
    logic                    psum_valid_q;

    assign lr          = last_round(bus.wsize);
    assign n_taps      = round_count(bus.wsize, bus.wround);
    assign first_round = (bus.wround == 3'd0);
    assign accept      = bus.MUL_DATA_valid && (bus.wsize <= WS_7X7) && (bus.wround <= lr);
    assign final_beat  = accept && (bus.wround == lr);

    always_comb begin
        tap_en = '0;
        for (int i = 0; i < TREE_IN; i++) begin
            tap_en[i] = (i < int'(n_taps));
        end
    end

    for (genvar l = 0; l < NUM_LANE; l++) begin : g_lane
        adder_tree16 u_tree (
            .prod (bus.MUL_results[l*SEG_W +: TREE_W]),
            .en   (tap_en),
            .sum  (round_sum[l])
        );

        // Only the first TREE_IN products of each segment ever carry kernel taps.
        assign unused_tail[l] = ^bus.MUL_results[l*SEG_W + TREE_W +: SEG_W - TREE_W];

        assign next_sum[l] = first_round ? round_sum[l] : acc[l] + round_sum[l];

`ifdef STRIDE_DECIM_EN
        assign lane_keep[l] = !(bus.stride && ((l % 2) == 1));
`else
        assign lane_keep[l] = 1'b1;
`endif
    end

`ifndef STRIDE_DECIM_EN
    logic unused_stride;
    assign unused_stride = bus.stride;
`endif

    always_ff @(posedge clk) begin
        if (rst_n) begin
            psum_valid_q <= 1'b0;
            psum_q       <= '0;
            for (int l = 0; l < NUM_LANE; l++) begin
                acc[l] <= '0;
            end
        end else begin
            psum_valid_q <= final_beat;
            if (accept) begin
                for (int l = 0; l < NUM_LANE; l++) begin
                    acc[l] <= next_sum[l];
                end
            end
            // The kernel total is taken from next_sum so the result lands one cycle after the final beat.
            if (final_beat) begin
                for (int l = 0; l < NUM_LANE; l++) begin
                    psum_q[l*OUT_W +: OUT_W] <= lane_keep[l] ? next_sum[l] : '0;
                end
            end
        end
    end

    assign bus.Psum_valid = psum_valid_q;
    assign bus.Psum       = psum_q;

endmodule

// File: tb/tb_psum_adder.sv
// tb/tb_psum_adder.sv - directed and randomized bench for psum_adder against a kernel-sum model
module tb_psum_adder;
    import psum_adder_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    psum_adder_if bus ();

    psum_adder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int     passed = 0;
    int     total  = 0;
    longint acc_m  [NUM_LANE];
    longint psum_m [NUM_LANE];
    logic   valid_m = 1'b0;

    function automatic int taps_of(input int ws);
        int k;
        k = 3 + 2 * ws;
        return k * k;
    endfunction

    // Kernel sum = sum of the first k*k products of the flattened round sequence of each lane.
    task automatic model_step();
        int     k2, last, r, idx;
        longint s;
        valid_m = 1'b0;
        if (rst_n) begin
            for (int l = 0; l < NUM_LANE; l++) begin
                acc_m[l]  = 0;
                psum_m[l] = 0;
            end
            return;
        end
        if (!bus.MUL_DATA_valid || bus.wsize > 4'd2) return;
        k2   = taps_of(int'(bus.wsize));
        last = (k2 + 15) / 16 - 1;
        r    = int'(bus.wround);
        if (r > last) return;
        for (int l = 0; l < NUM_LANE; l++) begin
            s = 0;
            for (int j = 0; j < 16; j++) begin
                idx = 16 * r + j;
                if (idx < k2) s += longint'($signed(bus.MUL_results[(l*128 + j)*16 +: 16]));
            end
            acc_m[l] = (r == 0) ? s : acc_m[l] + s;
        end
        if (r == last) begin
            valid_m = 1'b1;
            for (int l = 0; l < NUM_LANE; l++) begin
                psum_m[l] = acc_m[l];
`ifdef STRIDE_DECIM_EN
                if (bus.stride && (l % 2 == 1)) psum_m[l] = 0;
`endif
            end
        end
    endtask

    task automatic check(input string tag);
        logic [PSUM_W-1:0] exp_vec;
        for (int l = 0; l < NUM_LANE; l++) exp_vec[l*OUT_W +: OUT_W] = psum_m[l][OUT_W-1:0];
        total++;
        assert (bus.Psum_valid === valid_m) begin
            passed++;
        end else begin
            $error("FAIL %s valid observed=%0b expected=%0b", tag, bus.Psum_valid, valid_m);
        end
        total++;
        assert (bus.Psum === exp_vec) begin
            passed++;
        end else begin
            $error("FAIL %s psum observed=%h expected=%h", tag, bus.Psum, exp_vec);
        end
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check(tag);
    endtask

    task automatic beat(input int ws, input int wr, input bit v, input bit s);
        bus.wsize          = 4'(ws);
        bus.wround         = 3'(wr);
        bus.MUL_DATA_valid = v;
        bus.stride         = s;
    endtask

    task automatic idle(input string tag);
        bus.MUL_DATA_valid = 1'b0;
        tick(tag);
    endtask

    task automatic fill_const(input int v);
        for (int p = 0; p < NUM_LANE*SEG_PROD; p++) bus.MUL_results[p*16 +: 16] = 16'(v);
    endtask

    task automatic fill_lane_index();
        for (int p = 0; p < NUM_LANE*SEG_PROD; p++) bus.MUL_results[p*16 +: 16] = 16'(p / SEG_PROD);
    endtask

    task automatic fill_tail(input int from);
        for (int p = 0; p < NUM_LANE*SEG_PROD; p++)
            bus.MUL_results[p*16 +: 16] = ((p % SEG_PROD) >= from) ? 16'h7FFF : 16'h0000;
    endtask

    task automatic fill_random();
        for (int p = 0; p < NUM_LANE*SEG_PROD; p++) bus.MUL_results[p*16 +: 16] = 16'($urandom);
    endtask

    initial begin
        int ws, wsv, nb, wr;
        bus.MUL_results = '0;
        beat(0, 0, 1'b0, 1'b0);

        // reset, including a beat presented while reset is held
        fill_const(1);
        beat(0, 0, 1'b1, 1'b0);
        tick("reset_with_beat");
        idle("reset_hold");
        rst_n = 1'b0;
        idle("after_reset");

        // 3x3, all +1
        beat(0, 0, 1'b1, 1'b0);
        tick("t3x3_pulse");
        idle("t3x3_drop");

        // 7x7, products = lane index, consecutive rounds
        fill_lane_index();
        for (int r = 0; r < 4; r++) begin
            beat(2, r, 1'b1, 1'b0);
            tick("t7x7_round");
        end
        idle("t7x7_drop");

        // 5x5, all -2, gap between rounds
        fill_const(-2);
        beat(1, 0, 1'b1, 1'b0);
        tick("t5x5_r0");
        idle("t5x5_gap");
        beat(1, 1, 1'b1, 1'b0);
        tick("t5x5_r1");
        idle("t5x5_drop");

        // masked taps and ignored beats
        fill_tail(9);
        beat(0, 0, 1'b1, 1'b0);
        tick("mask_3x3");
        beat(5, 0, 1'b1, 1'b0);
        tick("invalid_wsize");
        beat(0, 1, 1'b1, 1'b0);
        tick("wround_past_last");
        beat(1, 0, 1'b1, 1'b0);
        tick("mask_5x5_r0");
        beat(1, 1, 1'b1, 1'b0);
        tick("mask_5x5_r1");
        fill_tail(1);
        beat(2, 3, 1'b1, 1'b0);
        tick("mask_7x7_r3");

        // reset mid-kernel discards partial sums
        fill_const(1);
        beat(2, 0, 1'b1, 1'b0);
        tick("mid_r0");
        beat(2, 1, 1'b1, 1'b0);
        tick("mid_r1");
        rst_n = 1'b1;
        idle("mid_reset");
        rst_n = 1'b0;
        beat(1, 1, 1'b1, 1'b0);
        tick("acc_cleared");
        beat(0, 0, 1'b1, 1'b0);
        tick("fresh_3x3");

        // stride handling, back-to-back kernels
        beat(0, 0, 1'b1, 1'b1);
        tick("stride1");
        beat(0, 0, 1'b1, 1'b0);
        tick("stride0");
        idle("stride_drop");

        // randomized kernels with gaps, stray rounds and invalid sizes
        for (int k = 0; k < 30; k++) begin
            ws  = $urandom_range(0, 3);
            wsv = (ws == 3) ? $urandom_range(3, 15) : ws;
            nb  = (ws == 3) ? 1 : (taps_of(ws) + 15) / 16;
            for (int r = 0; r < nb; r++) begin
                fill_random();
                if ($urandom_range(0, 3) == 0) idle("rand_gap");
                wr = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : r;
                beat(wsv, wr, 1'b1, 1'($urandom_range(0, 1)));
                tick("rand_beat");
            end
        end
        idle("final");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/psum_adder.md
Name: psum_adder

Overview:
- Partial-sum adder stage of the convolution engine; sits between the multiplier array (upstream) and the Psum buffer (downstream).
- Reduces one beat of 4608 signed 16-bit products into 36 lane sums per cycle.
- Accumulates lane sums across the rounds a kernel needs: 3x3 = 1 round, 5x5 = 2, 7x7 = 4.
- Emits one 36-lane Psum vector with a single-cycle valid pulse per completed kernel.

Parameters:
- PROD_W, 16, width of one signed product in MUL_results.
- NUM_LANE, 36, number of output lanes.
- SEG_PROD, 128, products per lane segment (NUM_LANE*SEG_PROD*PROD_W = 73728).
- TREE_IN, 16, products summed per lane per round.
- OUT_W, 24, signed width of one Psum lane (NUM_LANE*OUT_W = 864).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-high reset (name kept for codebase consistency; asserted = 1).
- wsize  in  4  kernel size: 0 = 3x3, 1 = 5x5, 2 = 7x7, 3..15 invalid.
- stride  in  1  0 = stride 1, 1 = stride 2.
- wround  in  3  round index of the current beat.
- MUL_results  in  73728  product vector; product p occupies bits [p*16+15 : p*16].
- MUL_DATA_valid  in  1  beat qualifier.
- Psum_valid  out  1  one-cycle pulse, Psum is complete.
- Psum  out  864  lane L occupies bits [L*24+23 : L*24], signed.

Behaviour:
- Reset (rst_n=1 at posedge): Psum_valid=0, Psum=0, all accumulators=0. Reset overrides a beat presented in the same cycle. Reset mid-kernel discards the partial sums.
- Segment of lane L = products L*128 .. L*128+127.
- Per round, lane L sums the first n products of its segment, all sign-extended:
  - n = min(16, k*k - 16*wround), with k = 3/5/7.
  - Products beyond n contribute 0.
  - Giving n per round: 3x3 r0=9; 5x5 r0=16, r1=9; 7x7 r0/r1/r2=16, r3=1.
- Last round: LR = 0 (3x3), 1 (5x5), 3 (7x7).
- Accepted beat (MUL_DATA_valid=1, wsize<=2, wround<=LR):
  - wround=0: acc_L <= round_sum_L.
  - Otherwise: acc_L <= acc_L + round_sum_L.
- On an accepted beat with wround==LR:
  - Next cycle: Psum_L = acc_L + round_sum_L (the full kernel sum) and Psum_valid=1.
  - Latency is 1 cycle from the final beat.
  - acc is not cleared; the next wround=0 beat overwrites it.
- Beats with wsize>2 or wround>LR are ignored: no acc update, no Psum_valid.
- MUL_DATA_valid=0: accumulators and Psum hold.
- Psum holds its last value until the next completion. Psum_valid is 1 only in the completion cycle.
- Rounds are supplied on consecutive or non-consecutive valid beats in order 0..LR. No ordering check is performed.
- A beat starting a new kernel (wround=0) on the cycle after completion is legal; full throughput is 1 beat/cycle.
- Arithmetic: two's complement. Worst case 49*2^15 fits 22 bits, so no overflow handling is required in 24 bits.

Optional Feature:
- STRIDE_DECIM_EN defined: when stride=1 at the final beat, odd lanes (L=1,3,..,35) of Psum are forced to 0; even lanes are unchanged.
- Not defined: stride is ignored; all 36 lanes carry sums.

Decomposition:
- Package psum_adder_pkg:
  - Width constants PROD_W, NUM_LANE, SEG_PROD, TREE_IN, OUT_W.
  - wsize encodings WS_3X3=0, WS_5X5=1, WS_7X7=2.
  - Function last_round(wsize) and function round_count(wsize, wround) returning n.
- One sub-module adder_tree16: combinational 16-input signed adder tree with a per-input enable mask; instantiated 36 times.

Test Plan:
- 3x3, all products +1, single beat wround=0 -> next cycle Psum_valid=1 for one cycle, every lane = 9.
- 7x7, products = lane index L (signed), beats wround 0,1,2,3 on consecutive cycles -> one pulse 1 cycle after wround=3; lane L = 49*L; no pulse earlier.
- 5x5, all products -2, wround 0 then 1 with a valid=0 gap between -> lanes = -50, pulse once after the wround=1 beat.
- Products at index >=16 (and >=9 for 3x3) set to 0x7FFF, others 0 -> all lanes 0; wsize=5 beat -> no pulse, Psum unchanged.
- rst_n=1 asserted after wround=1 of a 7x7, then fresh 3x3 beat of +1 -> lanes = 9, no stale pulse.
- With STRIDE_DECIM_EN, stride=1, 3x3 all +1 -> even lanes 9, odd lanes 0; stride=0 -> all lanes 9.
